// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the shared multiply/divide resources in EX.
// Launches one mult/multu/div/divu at a time, holds the EX stall until the
// result is latched, then issues exactly one HI/LO write. A frozen EX after
// the write parks in RETIRED so the same instruction is never relaunched.
//
// Optional build macro: MDU_DIVZERO_FAST_EN
//   defined   - div/divu with a zero divisor bypasses the divider and
//               completes in one stall cycle with HI=dividend, LO=all ones.
//   undefined - divide-by-zero runs through the divider like any other divide.
//
// state      | meaning
// IDLE       | no operation in flight, ready to accept
// MUL_WAIT   | waiting for the pipelined multiplier, cnt counts down
// DIV_BUSY   | iterative divider running, waiting for div_ready
// DONE       | result latched, HI/LO write this cycle
// RETIRED    | written, same instruction still frozen in EX

module mdu_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        stallreq,
    output logic        busy,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_BUSY,
        S_DONE,
        S_RETIRED
    } state_t;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            type_q  <= 2'b00;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            type_q  <= type_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state and operand/result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        type_d  = type_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    opa_d  = opa;
                    opb_d  = opb;
                    type_d = op_type;
                    if (!op_type[1]) begin
                        state_d = S_MUL_WAIT;
                        cnt_d   = MUL_LAT_C;
                    end else begin
`ifdef MDU_DIVZERO_FAST_EN
                        if (opb == 32'd0) begin
                            state_d = S_DONE;
                            hi_d    = opa;
                            lo_d    = 32'hFFFF_FFFF;
                        end else begin
                            state_d = S_DIV_BUSY;
                        end
`else
                        state_d = S_DIV_BUSY;
`endif
                    end
                end
            end
            S_MUL_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = mul_result[63:32];
                    lo_d    = mul_result[31:0];
                    state_d = S_DONE;
                end
            end
            S_DIV_BUSY: begin
                if (div_ready) begin
                    hi_d    = div_result[63:32];
                    lo_d    = div_result[31:0];
                    state_d = S_DONE;
                end
            end
            S_DONE:    state_d = ex_hold ? S_RETIRED : S_IDLE;
            S_RETIRED: if (!ex_hold) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Outputs; operands are only exposed while an operation owns the unit
    always_comb begin
        logic not_idle;
        not_idle    = (state_q != S_IDLE);
        busy        = not_idle;
        stallreq    = 1'b0;
        mul_signed  = 1'b0;
        mul_ina     = 32'd0;
        mul_inb     = 32'd0;
        div_signed  = 1'b0;
        div_opdata1 = 32'd0;
        div_opdata2 = 32'd0;
        div_start   = 1'b0;
        div_annul   = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_wdata    = 32'd0;
        lo_wdata    = 32'd0;
        if (not_idle) begin
            mul_signed  = (type_q == 2'b00);
            div_signed  = (type_q == 2'b10);
            mul_ina     = opa_q;
            mul_inb     = opb_q;
            div_opdata1 = opa_q;
            div_opdata2 = opb_q;
        end
        // rst gates the stall so every output is quiet while reset is held
        if (state_q == S_IDLE || state_q == S_MUL_WAIT || state_q == S_DIV_BUSY) begin
            stallreq = op_valid & ~flush & ~rst;
        end
        if (state_q == S_DIV_BUSY) begin
            div_start = ~div_ready & ~flush;
            div_annul = flush;
        end
        if (state_q == S_DONE && !flush) begin
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_wdata = hi_q;
            lo_wdata = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a
// behavioural multiplier/divider model and per-operation expectations.
// Build with MDU_DIVZERO_FAST_EN to include the fast divide-by-zero case.

module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk, rst, flush, ex_hold, op_valid;
    logic [1:0]  op_type;
    logic [31:0] opa, opb;
    logic        stallreq, busy, mul_signed, div_start, div_signed, div_annul;
    logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2;
    logic [63:0] mul_result, div_result;
    logic        div_ready;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int n_cmp = 0;
    int n_err = 0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
        .op_valid(op_valid), .op_type(op_type), .opa(opa), .opb(opb),
        .stallreq(stallreq), .busy(busy), .mul_signed(mul_signed),
        .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Multiplier model: product registered once, so it is valid MUL_LAT cycles
    // into MUL_WAIT (one register for MUL_LAT=2)
    logic [63:0] mul_r;
    always @(posedge clk) begin
        logic [63:0] xa, xb;
        xa = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
        xb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
        mul_r <= xa * xb;
    end
    assign mul_result = mul_r;

    // Divider model: ready after dlat consecutive cycles of div_start
    int   dlat = 1;
    int   dcnt;
    logic spur = 1'b0;
    logic [63:0] dres;
    always @(posedge clk or posedge rst) begin
        if (rst) dcnt <= 0;
        else     dcnt <= div_start ? dcnt + 1 : 0;
    end
    always_comb begin
        dres = '1;
        if (div_opdata2 != 32'd0) begin
            if (div_signed) begin
                dres[63:32] = $signed(div_opdata1) % $signed(div_opdata2);
                dres[31:0]  = $signed(div_opdata1) / $signed(div_opdata2);
            end else begin
                dres[63:32] = div_opdata1 % div_opdata2;
                dres[31:0]  = div_opdata1 / div_opdata2;
            end
        end
    end
    assign div_ready  = spur | (dlat != 0 && dcnt == dlat);
    assign div_result = div_ready ? dres : 64'hA5A5_5A5A_DEAD_BEEF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one operation from the current cycle (caller is just past a negedge).
    // h = RETIRED cycles requested via ex_hold, drop = release op_valid after launch.
    task automatic run_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                          input int dl, input int h, input bit drop, input string tag);
        int stall = 0, bsy = 0, dst = 0, hw = 0, lw = 0, ann = 0, r = 0;
        int es, eb, eds;
        bit done = 0, first = 1, fin = 0;
        logic [31:0] hd = 0, ld = 0, eh, el;
        logic [63:0] xa, xb, p;
        xa = (t == 2'b00) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (t == 2'b00) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        if (!t[1]) begin
            eh = p[63:32]; el = p[31:0]; es = MUL_LAT + 1; eds = 0;
        end else if (b == 32'd0) begin
`ifdef MDU_DIVZERO_FAST_EN
            eh = a; el = 32'hFFFF_FFFF; es = 1; eds = 0;
`else
            eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFF; es = dl + 2; eds = dl;
`endif
        end else if (t == 2'b10) begin
            eh = $signed(a) % $signed(b); el = $signed(a) / $signed(b); es = dl + 2; eds = dl;
        end else begin
            eh = a % b; el = a / b; es = dl + 2; eds = dl;
        end
        eb = es + h;
        if (drop) es = 1;
        dlat = dl;
        op_valid = 1'b1; op_type = t; opa = a; opb = b; ex_hold = 1'b0; flush = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            #1;
            stall += int'(stallreq);
            bsy   += int'(busy);
            dst   += int'(div_start);
            ann   += int'(div_annul);
            if (busy && first) begin
                first = 0;
                check({tag, " mul_signed"}, 64'(mul_signed), 64'(t == 2'b00));
                check({tag, " div_signed"}, 64'(div_signed), 64'(t == 2'b10));
                check({tag, " mul_ina"}, 64'(mul_ina), 64'(a));
                check({tag, " div_opdata2"}, 64'(div_opdata2), 64'(b));
            end
            if (hi_we) begin hw++; hd = hi_wdata; end
            if (lo_we) begin lw++; ld = lo_wdata; end
            if (r > h) begin
                fin = 1;
            end else begin
                if (hi_we && !done) begin
                    done = 1;
                    ex_hold = (h > 0);
                end
                @(negedge clk);
                if (drop) op_valid = 1'b0;
                if (done) begin
                    r++;
                    if (r > h) begin
                        op_valid = 1'b0;
                        ex_hold  = 1'b0;
                    end else begin
                        ex_hold = (r < h);
                    end
                end
            end
        end
        check({tag, " completed"}, 64'(fin), 64'd1);
        check({tag, " stall cycles"}, 64'(stall), 64'(es));
        check({tag, " busy cycles"}, 64'(bsy), 64'(eb));
        check({tag, " div_start cycles"}, 64'(dst), 64'(eds));
        check({tag, " annul cycles"}, 64'(ann), 64'd0);
        check({tag, " hi writes"}, 64'(hw), 64'd1);
        check({tag, " lo writes"}, 64'(lw), 64'd1);
        check({tag, " HI"}, 64'(hd), 64'(eh));
        check({tag, " LO"}, 64'(ld), 64'(el));
    endtask

    initial begin
        int wr;
        logic [1:0]  t;
        logic [31:0] a, b;

        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        op_valid = 1'b1; op_type = 2'b00; opa = 32'h1111_2222; opb = 32'h3333_4444;
        #1;
        check("reset stallreq", 64'(stallreq), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset mul_signed", 64'(mul_signed), 64'd0);
        check("reset hi_we", 64'(hi_we), 64'd0);
        check("reset mul_ina", 64'(mul_ina), 64'd0);
        op_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle div_opdata1", 64'(div_opdata1), 64'd0);
        check("idle div_start", 64'(div_start), 64'd0);
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 1, 0, 0, "multu_ex");
        @(negedge clk);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32, 0, 0, "div_ex");
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 4, 0, "mult_hold");
        @(negedge clk);
        spur = 1'b1;
        run_op(2'b00, 32'h0001_0003, 32'h8000_0001, 1, 0, 0, "mult_spur");
        spur = 1'b0;
        @(negedge clk);
        run_op(2'b11, 32'd1000, 32'd33, 6, 1, 1, "divu_drop");

        // Flush during a divide: one annul pulse, no write
        @(negedge clk);
        dlat = 40; op_valid = 1'b1; op_type = 2'b11; opa = 32'd5000; opb = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush div annul", 64'(div_annul), 64'd1);
        check("flush div start", 64'(div_start), 64'd0);
        check("flush div stallreq", 64'(stallreq), 64'd0);
        check("flush div hi_we", 64'(hi_we), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("after flush busy", 64'(busy), 64'd0);
        check("after flush annul", 64'(div_annul), 64'd0);
        wr = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk); #1;
            wr += int'(hi_we) + int'(lo_we) + int'(div_annul);
        end
        check("after flush quiet", 64'(wr), 64'd0);

        // Flush in IDLE with op_valid does not launch
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b00; opa = 32'd9; opb = 32'd9; flush = 1'b1;
        #1;
        check("idle flush stallreq", 64'(stallreq), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("idle flush busy", 64'(busy), 64'd0);

        // Flush on the DONE cycle suppresses the write
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b01; opa = 32'd6; opb = 32'd7;
        repeat (MUL_LAT + 1) @(negedge clk);
        #1;
        check("done cycle hi_we", 64'(hi_we), 64'd1);
        flush = 1'b1;
        #1;
        check("done flush hi_we", 64'(hi_we), 64'd0);
        check("done flush lo_we", 64'(lo_we), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        check("done flush busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        dlat = 40; op_valid = 1'b1; op_type = 2'b11; opa = 32'd77; opb = 32'd5;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst stallreq", 64'(stallreq), 64'd0);
        check("async rst div_start", 64'(div_start), 64'd0);
        check("async rst div_opdata1", 64'(div_opdata1), 64'd0);
        op_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd7, 9, 0, 0, "divu_after_rst");

`ifdef MDU_DIVZERO_FAST_EN
        @(negedge clk);
        run_op(2'b10, 32'h0000_1234, 32'd0, 5, 0, 0, "div_zero_fast");
`endif

        // Randomized operations, some back-to-back with no idle cycle
        for (int i = 0; i < 14; i++) begin
            t = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 20);
            if (b == 32'd0) b = 32'd1;
            if (t == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            run_op(t, a, b, $urandom_range(1, 40), $urandom_range(0, 3), 0, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the shared multiply/divide resources in EX. It accepts one mult/multu/div/divu operation from EX, launches it on the pipelined multiplier or the iterative divider, and holds the EX stall request until the result is available. It then issues exactly one HI/LO write, even if EX stays frozen by a downstream stall. It replaces ad-hoc start/stall logic in EX and is the single point driving div start/annul and the HI/LO write enables.

Parameters:
MUL_LAT, 2, multiplier result latency in cycles after operands are applied (1..15)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; asynchronous, active-high
flush  in  1  cancel any in-flight operation
ex_hold  in  1  EX register frozen by another stage this cycle
op_valid  in  1  EX holds a mul/div instruction
op_type  in  2  00 mult, 01 multu, 10 div, 11 divu
opa  in  32  rs operand (dividend / multiplicand)
opb  in  32  rt operand (divisor / multiplier)
stallreq  out  1  EX stall request
busy  out  1  state != IDLE
mul_signed  out  1  signed multiply select
mul_ina  out  32  multiplier operand A
mul_inb  out  32  multiplier operand B
mul_result  in  64  multiplier product
div_start  out  1  divider start, held high while dividing
div_signed  out  1  signed divide select
div_opdata1  out  32  dividend
div_opdata2  out  32  divisor
div_annul  out  1  divider abort, one-cycle pulse
div_result  in  64  {remainder, quotient}
div_ready  in  1  divider result valid
hi_we  out  1  HI write enable
lo_we  out  1  LO write enable
hi_wdata  out  32  HI write data
lo_wdata  out  32  LO write data

Behaviour:
- States: IDLE, MUL_WAIT, DIV_BUSY, DONE, RETIRED. On reset (async): state IDLE; all operand and result registers 0; every output 0.
- IDLE, op_valid=1, flush=0: latch opa, opb, op_type. Go to MUL_WAIT (cnt=MUL_LAT) or DIV_BUSY. stallreq=1 this cycle.
- Operand outputs drive from the latched registers only. They are 0 in IDLE.
- mul_signed = latched op_type==00. div_signed = latched op_type==10.
- MUL_WAIT: cnt decrements each cycle. When cnt reaches 1, latch mul_result and go to DONE. Stall lasts exactly MUL_LAT+1 cycles.
- DIV_BUSY: div_start=1 while div_ready=0.
- DIV_BUSY with div_ready=1: div_start=0. Latch div_result (HI=[63:32] remainder, LO=[31:0] quotient) and go to DONE.
- DONE: stallreq=0, hi_we=lo_we=1 for exactly this cycle, driving the latched result.
  - Next state is RETIRED if ex_hold=1, else IDLE.
- RETIRED: op_valid is ignored; the same instruction is still in EX. stallreq=0, no writes. Go to IDLE when ex_hold=0.
- stallreq = op_valid & (state in IDLE, MUL_WAIT, DIV_BUSY) & ~flush.
- flush in any state: next state IDLE, and hi_we/lo_we are forced 0 that cycle.
  - If state was DIV_BUSY: div_annul=1 for one cycle and div_start=0.
  - Flush in IDLE with op_valid=1 does not launch.
- op_valid dropping mid-operation (without flush) has no effect; the operation completes and writes.
- div_ready is ignored outside DIV_BUSY. mul_result is only sampled on the MUL_WAIT exit cycle.
- Back-to-back: in the cycle after DONE (state IDLE), a new op_valid launches immediately. This gives zero bubble between ops.

Optional Feature:
MDU_DIVZERO_FAST_EN
- Defined: a div/divu accepted in IDLE with opb==0 skips the divider and goes straight to DONE next cycle. The divider is never started. Result is HI=opa, LO=32'hFFFFFFFF. Total stall is 1 cycle.
- Undefined: divide-by-zero follows the normal DIV_BUSY path, and HI/LO take whatever the divider returns.

Test Plan:
- multu opa=0xFFFFFFFF opb=2, MUL_LAT=2, mul_result=0x1_FFFFFFFE -> stallreq high 3 cycles, then one cycle hi_we=lo_we=1, HI=0x00000001, LO=0xFFFFFFFE.
- div opa=-7 opb=2, divider ready after 33 cycles with {0xFFFFFFFF,0xFFFFFFFD} -> div_signed=1, div_start high until div_ready, single write HI=0xFFFFFFFF LO=0xFFFFFFFD, stallreq low on write cycle.
- divu in progress, flush at cycle 10 -> div_annul one-cycle pulse, state IDLE next cycle, no hi_we/lo_we ever, stallreq 0.
- mult completes while ex_hold=1 for 4 cycles with op_valid held -> exactly one hi_we/lo_we pulse, RETIRED for 4 cycles, no relaunch, then IDLE.
- rst asserted mid DIV_BUSY (asynchronously, between edges) -> all outputs 0 immediately; after release, divu opa=100 opb=7 -> HI=2 LO=14.
- With MDU_DIVZERO_FAST_EN: div opa=0x1234 opb=0 -> 1-cycle stall, div_start never high, HI=0x1234 LO=0xFFFFFFFF.
